multi_mode_ff_bank: RTL

//  WIDTH-bit bank of flip-flops. A mode input selects JK, D, T or SR next-state behaviour.

---
 rtl/multi_mode_ff_bank_pkg.sv | 23 ++
 rtl/ff_cell.sv | 39 +++
 rtl/multi_mode_ff_bank.sv | 71 +++++++
 3 files changed

// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared mode encodings and a width-bounded popcount for the multi-mode flip-flop bank.
package ff_bank_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // Widest bank the popcount helper supports, and the width of its result.
  localparam int POP_MAX_W = 64;
  localparam int POP_W     = 7;

  // Count set bits in the low 'width' bits of v; the bits above 'width' are ignored.
  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                input int width);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++)
      if (i < width) c = c + POP_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: combinational next state for JK/D/T/SR plus the SR S=R=1 flag.
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next,
  output logic       illegal_bit
);

  // Next-state decode; an S=R=1 bit holds its value and raises illegal_bit.
  always_comb begin
    q_next      = q;
    illegal_bit = 1'b0;
    case (mode)
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      default: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   illegal_bit = 1'b1;
          default: q_next = q;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit flip-flop bank with selectable JK/D/T/SR behaviour, a saturating
// flip counter and a sticky SR-illegal flag.
module multi_mode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [CNT_W-1:0] flip_cnt,
  output logic             illegal
);

  localparam int SUM_W = CNT_W + 1;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] ill_bits;
  logic [POP_W-1:0] flips;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic             ill_now;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .mode        (mode),
      .a           (a[i]),
      .b           (b[i]),
      .q           (q[i]),
      .q_next      (q_next[i]),
      .illegal_bit (ill_bits[i])
    );
  end

  assign qbar    = ~q;
  assign flips   = popcount(POP_MAX_W'(q_next ^ q), WIDTH);
  // One extra bit of headroom: a carry out means the counter would wrap, so clamp.
  assign cnt_sum = {1'b0, flip_cnt} + SUM_W'(flips);
  assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  // Cells only raise illegal_bit in SR mode, so no mode qualifier is needed here.
  assign ill_now = en & (|ill_bits);

  // Bank state register: loads the decoded next state on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RESET_VAL;
    else if (en) q <= q_next;
  end

  // Counter and sticky flag; clr beats the increment but not a fresh illegal event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flip_cnt <= '0;
      illegal  <= 1'b0;
    end else if (clr) begin
      flip_cnt <= '0;
      illegal  <= ill_now;
    end else if (en) begin
      flip_cnt <= cnt_sat;
      illegal  <= illegal | ill_now;
    end
  end

endmodule
